// File: rtl/fp_add_arb_pkg.sv
// rtl/fp_add_arb_pkg.sv - shared constants, id-width helper and tag type for fp_add_arbiter
package fp_add_arb_pkg;

  localparam int FPU_LATENCY_DEFAULT = 11;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

  typedef struct packed {
    logic       valid;
    logic [3:0] id;
  } fp_tag_t;

endpackage

// File: rtl/fp_add_arbiter_if.sv
// rtl/fp_add_arbiter_if.sv - requester, response and fp_add signals of fp_add_arbiter
interface fp_add_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_data;
  logic [31:0]           fpu_a;
  logic [31:0]           fpu_b;
  logic [31:0]           fpu_result;

  modport master (
    output req_valid, req_a, req_b, fpu_result,
    input  req_ready, rsp_valid, rsp_data, fpu_a, fpu_b
  );

  modport slave (
    input  req_valid, req_a, req_b, fpu_result,
    output req_ready, rsp_valid, rsp_data, fpu_a, fpu_b
  );
endinterface

// File: rtl/fp_add_arbiter_rr_arbiter.sv
// rtl/fp_add_arbiter_rr_arbiter.sv - round-robin one-hot arbiter searching upward from ptr
module rr_arbiter
  import fp_add_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx
);

  logic found;
  int   j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - shares one fixed-latency fp_add among NUM_REQ requesters
// Optional FP_ADD_ARB_STATS_EN adds saturating grant/busy counters on stat_grants/stat_busy.
module fp_add_arbiter
  import fp_add_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int FPU_LATENCY     = FPU_LATENCY_DEFAULT,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  fp_add_arbiter_if.slave       bus,
  output logic [NUM_REQ*32-1:0] stat_grants,
  output logic [31:0]           stat_busy
);

  localparam int IDW   = clog2(NUM_REQ);
  localparam int CW    = clog2(MAX_OUTSTANDING + 1);
  localparam int DEPTH = FPU_LATENCY + 1;

  fp_tag_t            tag_q [DEPTH];
  fp_tag_t            tag_in;
  logic [CW-1:0]      cnt_q [NUM_REQ];
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     gnt_idx;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] retire;
  logic               any_gnt;
  logic [31:0]        fpu_a_q;
  logic [31:0]        fpu_b_q;
  logic [31:0]        rsp_data_q;
  logic [NUM_REQ-1:0] rsp_valid_q;

  // A tag leaving the pipe this cycle frees its slot, so a full requester regrants without a bubble.
  always_comb begin
    retire   = '0;
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      retire[i]   = tag_q[DEPTH-1].valid && (tag_q[DEPTH-1].id == 4'(i));
      eligible[i] = !reset && bus.req_valid[i] &&
                    ((cnt_q[i] < CW'(MAX_OUTSTANDING)) || retire[i]);
    end
  end

  rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_rr (
    .req     (eligible),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign any_gnt        = |gnt;
  assign tag_in.valid   = any_gnt;
  assign tag_in.id      = 4'(gnt_idx);
  assign bus.req_ready  = gnt;
  assign bus.fpu_a      = fpu_a_q;
  assign bus.fpu_b      = fpu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int k = 0; k < DEPTH; k++) tag_q[k] <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int k = 1; k < DEPTH; k++) tag_q[k] <= tag_q[k-1];
      if (any_gnt) begin
        fpu_a_q <= bus.req_a[gnt_idx*32 +: 32];
        fpu_b_q <= bus.req_b[gnt_idx*32 +: 32];
        ptr_q   <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IDW'(1);
      end
      rsp_valid_q <= retire;
      if (|retire) rsp_data_q <= bus.fpu_result;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && !retire[i])      cnt_q[i] <= cnt_q[i] + CW'(1);
        else if (retire[i] && !gnt[i]) cnt_q[i] <= cnt_q[i] - CW'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt_chk
    assert property (@(posedge clock) disable iff (reset)
      !(gnt[gi] && !retire[gi] && cnt_q[gi] == CW'(MAX_OUTSTANDING)));
    assert property (@(posedge clock) disable iff (reset)
      !(retire[gi] && !gnt[gi] && cnt_q[gi] == '0));
  end

`ifdef FP_ADD_ARB_STATS_EN
  logic [31:0] grants_q [NUM_REQ];
  logic [31:0] busy_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) grants_q[i] <= '0;
    end else begin
      if (any_gnt && busy_q != '1) busy_q <= busy_q + 32'd1;
      for (int i = 0; i < NUM_REQ; i++)
        if (gnt[i] && grants_q[i] != '1) grants_q[i] <= grants_q[i] + 32'd1;
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_grants[i*32 +: 32] = grants_q[i];
  end
  assign stat_busy = busy_q;
`else
  assign stat_grants = '0;
  assign stat_busy   = '0;
`endif

endmodule
